// File: rtl/ikaopll_dac_collector_if.sv
// PCM sample stream from the OPLL DAC collector (master) to a host audio sink (slave).
// With IKAOPLL_COLLECTOR_FRAMETAG_EN defined, an 8-bit frame tag travels with each sample.
interface ikaopll_dac_collector_if;
  logic        smpl_valid;
  logic [15:0] smpl_data;
  logic        smpl_ready;
`ifdef IKAOPLL_COLLECTOR_FRAMETAG_EN
  logic [7:0]  smpl_tag;

  modport master (
    output smpl_valid,
    output smpl_data,
    output smpl_tag,
    input  smpl_ready
  );

  modport slave (
    input  smpl_valid,
    input  smpl_data,
    input  smpl_tag,
    output smpl_ready
  );
`else
  modport master (
    output smpl_valid,
    output smpl_data,
    input  smpl_ready
  );

  modport slave (
    input  smpl_valid,
    input  smpl_data,
    output smpl_ready
  );
`endif
endinterface

// File: rtl/ikaopll_dac_collector.sv
// Collects one 18-slot OPLL frame of impulse-DAC words, mixes melody/rhythm into a 16-bit PCM
// sample and queues it in a small FIFO. Optional frame tags: IKAOPLL_COLLECTOR_FRAMETAG_EN.
module ikaopll_dac_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_SHIFT  = 3
) (
  input  logic                    i_EMUCLK,
  input  logic                    i_RST,
  input  logic                    i_phi1_NCEN_n,
  input  logic                    i_CYCLE_00,
  input  logic                    i_DAC_EN_MO,
  input  logic                    i_DAC_EN_RO,
  input  logic                    i_IMP_SIGN,
  input  logic [7:0]              i_IMP_MAG,
  input  logic signed [4:0]       i_MOVOL,
  input  logic signed [4:0]       i_ROVOL,
  ikaopll_dac_collector_if.master smpl_if,
  output logic                    o_OVERFLOW
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

`ifdef IKAOPLL_COLLECTOR_FRAMETAG_EN
  typedef struct packed {
    logic [7:0]         tag;
    logic signed [15:0] pcm;
  } smpl_t;
`else
  typedef struct packed {
    logic signed [15:0] pcm;
  } smpl_t;
`endif

  // 13-bit accumulate with clamping at +4095 / -4096
  function automatic logic signed [12:0] acc_add(input logic signed [12:0] a,
                                                 input logic signed [9:0]  b);
    logic [13:0] s;
    s = {a[12], a} + {{4{b[9]}}, b};
    if (s[13] != s[12]) acc_add = s[13] ? 13'sh1000 : 13'sh0FFF;
    else                acc_add = s[12:0];
  endfunction

  // ---------------------------------------------------------------- frame accumulation
  logic signed [12:0] r_acc_mo, r_acc_ro;
  logic signed [12:0] r_hold_mo, r_hold_ro;
  logic               r_synced;
  logic               r_mix_req;

  logic               w_tick, w_frame;
  logic signed [9:0]  w_word;
  logic signed [12:0] w_base_mo, w_base_ro, w_acc_mo_nx, w_acc_ro_nx;

  assign w_tick  = ~i_phi1_NCEN_n;
  assign w_frame = w_tick & i_CYCLE_00;
  // Negative words are the one's complement of the magnitude: -(MAG+1)
  assign w_word  = i_IMP_SIGN ? {2'b11, ~i_IMP_MAG} : {2'b00, i_IMP_MAG};

  assign w_base_mo   = i_CYCLE_00 ? '0 : r_acc_mo;
  assign w_base_ro   = i_CYCLE_00 ? '0 : r_acc_ro;
  assign w_acc_mo_nx = i_DAC_EN_MO ? acc_add(w_base_mo, w_word) : w_base_mo;
  assign w_acc_ro_nx = i_DAC_EN_RO ? acc_add(w_base_ro, w_word) : w_base_ro;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_acc_mo  <= '0;
      r_acc_ro  <= '0;
      r_hold_mo <= '0;
      r_hold_ro <= '0;
      r_synced  <= 1'b0;
      r_mix_req <= 1'b0;
    end else begin
      if (w_tick) begin
        r_acc_mo <= w_acc_mo_nx;
        r_acc_ro <= w_acc_ro_nx;
      end
      if (w_frame) begin
        r_hold_mo <= r_acc_mo;
        r_hold_ro <= r_acc_ro;
        r_synced  <= 1'b1;
      end
      r_mix_req <= w_frame & r_synced;
    end
  end

  // ---------------------------------------------------------------- mix stage
  logic signed [17:0] w_prod_mo, w_prod_ro;
  logic signed [18:0] w_mix;
  logic signed [25:0] w_shifted;
  logic signed [15:0] w_pcm;

  assign w_prod_mo = 18'(r_hold_mo) * 18'(i_MOVOL);
  assign w_prod_ro = 18'(r_hold_ro) * 18'(i_ROVOL);
  assign w_mix     = 19'(w_prod_mo) + 19'(w_prod_ro);
  assign w_shifted = 26'(w_mix) <<< OUT_SHIFT;

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    w_pcm = w_shifted[15:0];
    if (w_shifted[25:15] != {11{w_shifted[25]}})
      w_pcm = w_shifted[25] ? 16'sh8000 : 16'sh7FFF;
  end

  smpl_t r_mix;
  logic  r_push;
`ifdef IKAOPLL_COLLECTOR_FRAMETAG_EN
  logic [7:0] r_frame_cnt;
`endif

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_mix  <= '0;
      r_push <= 1'b0;
`ifdef IKAOPLL_COLLECTOR_FRAMETAG_EN
      r_frame_cnt <= '0;
`endif
    end else begin
      r_push <= r_mix_req;
      if (r_mix_req) begin
        r_mix.pcm <= w_pcm;
`ifdef IKAOPLL_COLLECTOR_FRAMETAG_EN
        r_mix.tag <= r_frame_cnt;
`endif
      end
`ifdef IKAOPLL_COLLECTOR_FRAMETAG_EN
      if (w_frame && r_synced) r_frame_cnt <= r_frame_cnt + 8'd1;
`endif
    end
  end

  // ---------------------------------------------------------------- sample FIFO
  smpl_t          r_mem [FIFO_DEPTH];
  smpl_t          r_head, w_head_nx;
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr, w_rd_ptr_nx1;
  logic [CW-1:0]  r_count;
  logic           r_overflow;
  logic           w_valid, w_full, w_pop, w_wr;

  assign w_valid      = (r_count != '0);
  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_pop        = w_valid & smpl_if.smpl_ready;
  // A full FIFO still accepts a push on the same edge as a pop
  assign w_wr         = r_push & (~w_full | w_pop);
  assign w_rd_ptr_nx1 = r_rd_ptr + AW'(1);

  // NOTE: the storage array has no reset; r_count alone decides which entries are live.
  always_ff @(posedge i_EMUCLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_mix;
  end

  // Head register tracks the entry at r_rd_ptr; it keeps its value once the FIFO drains
  always_comb begin
    w_head_nx = r_head;
    if (w_pop) begin
      if (r_count > CW'(1)) w_head_nx = r_mem[w_rd_ptr_nx1];
      else if (w_wr)        w_head_nx = r_mix;
    end else if (!w_valid && w_wr) begin
      w_head_nx = r_mix;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= w_rd_ptr_nx1;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      r_head  <= w_head_nx;
      if (r_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  assign smpl_if.smpl_valid = w_valid;
  assign smpl_if.smpl_data  = r_head.pcm;
`ifdef IKAOPLL_COLLECTOR_FRAMETAG_EN
  assign smpl_if.smpl_tag   = r_head.tag;
`endif
  assign o_OVERFLOW = r_overflow;

endmodule
